// File: rtl/fft_power_spectrum.sv
// fft_power_spectrum: per-bin power |X|^2 = re^2 + im^2 of a complex FFT output stream.
// Two-stage valid/ready pipeline with full backpressure; each result carries its bin index
// and an end-of-frame flag. Optional frame peak tracker is built when the macro
// FFT_POWER_PEAK_DETECT_EN is defined; otherwise the peak_* ports are tied to zero.
module fft_power_spectrum #(
  parameter int unsigned  FFT_SIZE   = 1024,
  parameter int unsigned  DATA_WIDTH = 16,
  localparam int unsigned BIN_W      = $clog2(FFT_SIZE),
  localparam int unsigned PWR_W      = 2 * DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  input  logic [2*DATA_WIDTH-1:0] in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [PWR_W-1:0]        out_power_o,
  output logic [BIN_W-1:0]        out_bin_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    peak_valid_o,
  output logic [BIN_W-1:0]        peak_bin_o,
  output logic [PWR_W-1:0]        peak_power_o
);

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(FFT_SIZE - 1);

  // Sign-extended operands so the products are formed at full power width.
  logic signed [PWR_W-1:0] re_ext;
  logic signed [PWR_W-1:0] im_ext;
  logic signed [PWR_W-1:0] re_sq;
  logic signed [PWR_W-1:0] im_sq;

  logic                    s1_valid_q;
  logic signed [PWR_W-1:0] s1_re_sq_q;
  logic signed [PWR_W-1:0] s1_im_sq_q;
  logic [BIN_W-1:0]        s1_bin_q;

  logic                    s2_valid_q;
  logic [PWR_W-1:0]        s2_power_q;
  logic [BIN_W-1:0]        s2_bin_q;
  logic                    s2_last_q;

  logic [BIN_W-1:0]        bin_q;

  logic s1_ready;
  logic s2_ready;
  logic in_hs;

  assign re_ext = {{DATA_WIDTH{in_data_i[PWR_W-1]}}, in_data_i[PWR_W-1:DATA_WIDTH]};
  assign im_ext = {{DATA_WIDTH{in_data_i[DATA_WIDTH-1]}}, in_data_i[DATA_WIDTH-1:0]};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  // A stage can take new data when it is empty or its content moves on this edge.
  assign s2_ready   = !s2_valid_q | out_ready_i;
  assign s1_ready   = !s1_valid_q | s2_ready;
  assign in_ready_o = s1_ready & !clear_i & !rst_i;
  assign in_hs      = in_valid_i & in_ready_o;

  // Bin counter: advances per accepted sample, restarts on clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q <= '0;
    end else if (clear_i) begin
      bin_q <= '0;
    end else if (in_hs) begin
      bin_q <= (bin_q == LastBin) ? '0 : bin_q + BIN_W'(1);
    end
  end

  // Stage 1: squares of re and im plus the bin tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_re_sq_q <= '0;
      s1_im_sq_q <= '0;
      s1_bin_q   <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
    end else if (s1_ready) begin
      s1_valid_q <= in_hs;
      if (in_hs) begin
        s1_re_sq_q <= re_sq;
        s1_im_sq_q <= im_sq;
        s1_bin_q   <= bin_q;
      end
    end
  end

  // Stage 2: unsigned sum (both squares are non-negative, the sum fits PWR_W).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_power_q <= '0;
      s2_bin_q   <= '0;
      s2_last_q  <= 1'b0;
    end else if (clear_i) begin
      s2_valid_q <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_power_q <= $unsigned(s1_re_sq_q) + $unsigned(s1_im_sq_q);
        s2_bin_q   <= s1_bin_q;
        s2_last_q  <= (s1_bin_q == LastBin);
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_power_o = s2_power_q;
  assign out_bin_o   = s2_bin_q;
  assign out_last_o  = s2_last_q;

`ifdef FFT_POWER_PEAK_DETECT_EN
  logic             out_hs;
  logic [PWR_W-1:0] max_q;
  logic [BIN_W-1:0] max_bin_q;
  logic             max_load;
  logic [PWR_W-1:0] max_next;
  logic [BIN_W-1:0] max_bin_next;
  logic             peak_valid_q;
  logic [BIN_W-1:0] peak_bin_q;
  logic [PWR_W-1:0] peak_power_q;

  // Clear wins over the output handshake, so a discarded result never reaches the tracker.
  assign out_hs = s2_valid_q & out_ready_i & !clear_i;

  // Running maximum including the result leaving this cycle; strict '>' keeps the lowest bin.
  always_comb begin
    max_load     = (s2_bin_q == '0) || (s2_power_q > max_q);
    max_next     = max_load ? s2_power_q : max_q;
    max_bin_next = max_load ? s2_bin_q : max_bin_q;
  end

  // Tracker update per output handshake; publish and restart on the frame's last bin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_q        <= '0;
      max_bin_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_power_q <= '0;
    end else if (clear_i) begin
      max_q        <= '0;
      max_bin_q    <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (out_hs) begin
        max_q     <= max_next;
        max_bin_q <= max_bin_next;
        if (s2_last_q) begin
          peak_valid_q <= 1'b1;
          peak_bin_q   <= max_bin_next;
          peak_power_q <= max_next;
          max_q        <= '0;
          max_bin_q    <= '0;
        end
      end
    end
  end

  assign peak_valid_o = peak_valid_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_power_o = peak_power_q;
`else
  assign peak_valid_o = 1'b0;
  assign peak_bin_o   = '0;
  assign peak_power_o = '0;
`endif

endmodule

// File: tb/tb_fft_power_spectrum.sv
// tb_fft_power_spectrum: randomized stream against a queue-based reference model of the
// power pipeline, plus directed literal checks. Peak checks follow FFT_POWER_PEAK_DETECT_EN.
module tb_fft_power_spectrum;

  localparam int FftSize   = 8;
  localparam int DataWidth = 16;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_power;
  logic [2:0]  out_bin;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        peak_valid;
  logic [2:0]  peak_bin;
  logic [31:0] peak_power;

  fft_power_spectrum #(
    .FFT_SIZE  (FftSize),
    .DATA_WIDTH(DataWidth)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_power_o (out_power),
    .out_bin_o   (out_bin),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .peak_valid_o(peak_valid),
    .peak_bin_o  (peak_bin),
    .peak_power_o(peak_power)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pwr;
    int          bin;
    bit          last;
    longint      acc;
  } item_t;

  typedef struct {
    logic [31:0] pwr;
    int          bin;
    bit          last;
  } obs_t;

  item_t  q[$];      // samples accepted and not yet delivered, oldest first
  obs_t   got[$];    // results the DUT actually delivered
  obs_t   pk_log[$]; // peak pulses the DUT produced
  int     bin_m = 0;
  longint edges = 0;
  logic [31:0] m_max = '0;
  int          m_max_bin = 0;
  logic [31:0] pk_pwr_m = '0;
  int          pk_bin_m = 0;
  bit          pulse_m = 1'b0;

  function automatic logic [31:0] pwr_of(input logic [31:0] d);
    longint r;
    longint i;
    r = longint'($signed(d[31:16]));
    i = longint'($signed(d[15:0]));
    return 32'(r * r + i * i);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    bit          exp_rdy;
    bit          exp_vld;
    bit          exp_pv;
    int          exp_pb;
    logic [31:0] exp_pp;
    item_t       it;
    obs_t        ob;
    if (rst) begin
      checks++;
      if ({in_ready, out_valid, out_power, out_bin, out_last, peak_valid, peak_bin,
           peak_power} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got rdy=%0b vld=%0b pwr=%0h pv=%0b expected all 0",
                 in_ready, out_valid, out_power, peak_valid);
      end
      q.delete();
      bin_m = 0; m_max = '0; m_max_bin = 0; pk_pwr_m = '0; pk_bin_m = 0; pulse_m = 1'b0;
    end else begin
      exp_rdy = !clear && (q.size() < 2 || out_ready);
      exp_vld = (q.size() > 0) && (q[0].acc < edges);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %0b expected %0b", in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== exp_vld) begin
        errors++;
        $display("FAIL out_valid: got %0b expected %0b", out_valid, exp_vld);
      end
      if (exp_vld && out_valid) begin
        checks++;
        if (out_power !== q[0].pwr || int'(out_bin) != q[0].bin || out_last !== q[0].last) begin
          errors++;
          $display("FAIL out_data: got pwr=%0h bin=%0d last=%0b expected pwr=%0h bin=%0d last=%0b",
                   out_power, out_bin, out_last, q[0].pwr, q[0].bin, q[0].last);
        end
      end
`ifdef FFT_POWER_PEAK_DETECT_EN
      exp_pv = pulse_m; exp_pb = pk_bin_m; exp_pp = pk_pwr_m;
`else
      exp_pv = 1'b0; exp_pb = 0; exp_pp = '0;
`endif
      checks++;
      if (peak_valid !== exp_pv || int'(peak_bin) != exp_pb || peak_power !== exp_pp) begin
        errors++;
        $display("FAIL peak: got v=%0b bin=%0d pwr=%0d expected v=%0b bin=%0d pwr=%0d",
                 peak_valid, peak_bin, peak_power, exp_pv, exp_pb, exp_pp);
      end
      if (peak_valid) begin
        ob.pwr = peak_power; ob.bin = int'(peak_bin); ob.last = 1'b1;
        pk_log.push_back(ob);
      end
      if (out_valid && out_ready && !clear) begin
        ob.pwr = out_power; ob.bin = int'(out_bin); ob.last = out_last;
        got.push_back(ob);
      end
      pulse_m = 1'b0;
      if (clear) begin
        q.delete();
        bin_m = 0; m_max = '0; m_max_bin = 0;
      end else begin
        if (exp_vld && out_ready) begin
          it = q.pop_front();
          if (it.bin == 0 || it.pwr > m_max) begin
            m_max = it.pwr; m_max_bin = it.bin;
          end
          if (it.last) begin
            pulse_m = 1'b1; pk_pwr_m = m_max; pk_bin_m = m_max_bin;
            m_max = '0; m_max_bin = 0;
          end
        end
        if (in_valid && exp_rdy) begin
          it.pwr = pwr_of(in_data); it.bin = bin_m; it.last = (bin_m == FftSize - 1);
          it.acc = edges + 1;
          q.push_back(it);
          bin_m = (bin_m + 1) % FftSize;
        end
      end
    end
    edges++;
  end

  // Present one sample and hold it until accepted; called and returns at posedge+1.
  task automatic send(input logic [15:0] re, input logic [15:0] im);
    bit hs;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = {re, im};
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 50);
    chk("send_accepted", longint'(hs), 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("wait_results", longint'(got.size() >= n), 1);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    int base;
    int acc;
    int k;
    bit hs;
    int n;

    // Reset held with random inputs.
    repeat (4) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // First sample: 2-cycle latency, 3^2 + (-4)^2 = 25.
    send(16'd3, 16'hFFFC);
    @(negedge clk);
    chk("latency_not_yet", longint'(out_valid), 0);
    @(negedge clk);
    chk("latency_valid", longint'(out_valid), 1);
    chk("first_power", longint'(out_power), 25);
    chk("first_bin", longint'(out_bin), 0);
    chk("first_last", longint'(out_last), 0);
    @(posedge clk);
    #1;

    // Extremes.
    base = got.size();
    send(16'h8000, 16'h8000);
    send(16'h7FFF, 16'h0000);
    wait_got(base + 2);
    chk("neg_full_power", longint'(got[base].pwr), longint'(32'h8000_0000));
    chk("neg_full_bin", got[base].bin, 1);
    chk("pos_full_power", longint'(got[base+1].pwr), longint'(32'h3FFF_0001));

    // Clear with stalled pending results at bin 3.
    out_ready = 1'b0;
    base = got.size();
    send(16'd1, 16'd0);
    send(16'd2, 16'd0);
    @(negedge clk);
    chk("pending_valid", longint'(out_valid), 1);
    chk("pending_bin", longint'(out_bin), 3);
    @(posedge clk);
    #1;
    do_clear();
    out_ready = 1'b1;
    send(16'd5, 16'd0);
    wait_got(base + 1);
    repeat (4) @(posedge clk);
    #1;
    chk("clear_dropped", got.size(), base + 1);
    chk("clear_next_bin", got[base].bin, 0);
    chk("clear_next_power", longint'(got[base].pwr), 25);

    // Full frame re=k plus one wrap sample.
    do_clear();
    base = got.size();
    for (int i = 0; i < 9; i++) send(16'(i), 16'd0);
    wait_got(base + 9);
    for (int i = 0; i < 9; i++) begin
      chk("frame_power", longint'(got[base+i].pwr), (i % 9) * (i % 9));
      chk("frame_bin", got[base+i].bin, i % 8);
      chk("frame_last", longint'(got[base+i].last), longint'(i == 7));
    end

    // Backpressure: six stalled cycles accept exactly two samples.
    do_clear();
    out_ready = 1'b0;
    base = got.size();
    acc = 0; k = 1;
    in_valid = 1'b1; in_data = {16'(k), 16'd0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        acc++; k++; in_data = {16'(k), 16'd0};
      end
    end
    chk("stall_accepted", acc, 2);
    @(negedge clk);
    chk("stall_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 20);
    in_valid = 1'b0;
    wait_got(base + 3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_order_bin", got[base+i].bin, i);
      chk("stall_order_power", longint'(got[base+i].pwr), (i + 1) * (i + 1));
    end

`ifdef FFT_POWER_PEAK_DETECT_EN
    // Peak: powers {4,9,9,1,0,0,0,0}; tie at 9 keeps bin 1.
    do_clear();
    base = got.size();
    n = pk_log.size();
    send(16'd2, 16'd0); send(16'd3, 16'd0); send(16'hFFFD, 16'd0); send(16'd1, 16'd0);
    for (int i = 0; i < 4; i++) send(16'd0, 16'd0);
    wait_got(base + 8);
    repeat (3) @(posedge clk);
    #1;
    chk("peak_pulses", pk_log.size(), n + 1);
    if (pk_log.size() > n) begin
      chk("peak_bin", pk_log[n].bin, 1);
      chk("peak_power", longint'(pk_log[n].pwr), 9);
    end
`endif

    // Randomized stream with random backpressure, clears and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || hs) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       in_data = {16'h8000, 16'h8000};
          1:       in_data = {16'h7FFF, 16'h8000};
          default: in_data = $urandom;
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 60) == 0);
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
    end
    clear = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (in_valid && n < 20) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
